mem_wr_arbiter: RTL and testbench
=================================

# mem_wr_arbiter

Parametrised write-side arbiter between the switch ingress ports and the shared packet memory bank. It generalises the fixed three-port slot arbiter to `pPORTS` inputs of `pDATA_W` bits. Each port gets a small skid FIFO with a ready signal, and the block offers two modes: legacy fixed time-slot (TDM) or work-conserving round-robin, with optional frame lock. Granted words go out on a single registered memory-write channel, tagged with the source port number, and honour memory backpressure.

## Interface

Parameters:

- `pPORTS`, 3: number of ingress ports, 2..8.
- `pDATA_W`, 32: data word width.
- `pFIFO_DEPTH`, 4: per-port FIFO depth; power of 2, at least 2.
- `pMODE`, 1: 0 = fixed TDM slot per cycle; 1 = work-conserving round-robin.
- `pFRAME_LOCK`, 0: 1 = hold the grant from SOF to EOF (only meaningful when `pMODE`=1).
- `pTAG_W`, `$clog2(pPORTS+1)`: width of the port tag.

Ports. Clock is `i_clk`. Reset is `i_reset`, synchronous and active-high.

- `i_clk` in 1: clock.
- `i_reset` in 1: synchronous active-high reset.
- `i_valid` in pPORTS: bit p means port p presents a word.
- `i_data` in pPORTS*pDATA_W: port p occupies bits [p*pDATA_W +: pDATA_W].
- `i_info` in 2*pPORTS: per-port frame marker. 01 = SOF, 10 = EOF, 11 = single-word frame, 00 = middle word.
- `i_extra_byte` in 2*pPORTS: per-port count of valid bytes in the last word.
- `o_ready` in the out direction, pPORTS: per-port FIFO not full.
- `o_overflow` out pPORTS: sticky per-port drop flag.
- `i_mem_ready` in 1: memory accepts the current output word.
- `o_en_mem` out 1: output word valid.
- `o_data` out pDATA_W: output word.
- `o_port_num` out pTAG_W: source port, numbered p+1 (0 never issued).
- `o_info_port` out 2: frame marker of the output word.
- `o_extra_byte` out 2: valid-byte count of the output word.

## Operation

Per-port FIFO:

- Each entry stores {data, info, extra_byte}.
- Push when `i_valid[p]` is high and `o_ready[p]` is high.
- `o_ready[p]` is the inverse of full, decoded from the registered count. A full FIFO refuses a push even in a cycle where it is popped.
- `i_valid[p]` high while full: the word is dropped, FIFO contents are unchanged, and `o_overflow[p]` is set. It is cleared only by reset.
- Read and write pointers are log2(pFIFO_DEPTH) bits and wrap naturally. Count is log2(pFIFO_DEPTH)+1 bits.

Output slot:

- The slot is free when `o_en_mem`=0 or `i_mem_ready`=1.
- Arbitration and pop happen only when the slot is free.
- While the slot is not free, all output registers hold and no FIFO pops.

Mode 0 (TDM):

- Slot pointer `r_slot` advances by one per free-slot cycle and wraps from pPORTS-1 to 0.
- If FIFO[r_slot] is non-empty, pop it into the output and set `o_en_mem`=1.
- Otherwise set `o_en_mem`=0. The slot is wasted.

Mode 1 (round-robin):

- Search ports `r_last`+1, `r_last`+2, … with wrap, and grant the first non-empty FIFO.
- On a grant, set `r_last` to the granted port.
- If no FIFO is non-empty, set `o_en_mem`=0.

Frame lock (`pMODE`=1, `pFRAME_LOCK`=1):

- Popping an SOF word (info 01) from port p sets the lock to p.
- While locked, only port p is eligible. If its FIFO is empty, `o_en_mem`=0 (bubble).
- Popping info 10 or 11 releases the lock. Round-robin then resumes from p+1.
- Info 11 never sets the lock.

Reset state:

- All FIFOs empty; `o_ready` all 1; `o_overflow` 0.
- `o_en_mem` 0; `o_data` 0; `o_port_num` 0; `o_info_port` 00; `o_extra_byte` 00.
- `r_slot` = 0; `r_last` = pPORTS-1; lock cleared.
- Reset mid-frame discards buffered words and any in-flight output word without completing it.

## Timing

- Push sampled at edge k. The word is eligible at edge k+1 and appears on the outputs after edge k+1. Minimum latency is 1 cycle from the input edge, with no bypass.
- All outputs are registered; no combinational path from any input to any output.
- The `o_ready` → `i_valid` handshake is same-cycle.
- Output hold: if `o_en_mem`=1 and `i_mem_ready`=0, `o_data`, `o_port_num`, `o_info_port` and `o_extra_byte` stay stable until the edge where `i_mem_ready`=1.
- Throughput: one word per cycle when `i_mem_ready`=1. In mode 1 this holds whenever any FIFO is non-empty, except for frame-lock bubbles.
- Simultaneous push and pop on a non-full FIFO: count is unchanged and both complete.

## Test plan

- **Single port, mode 1.** Port 1 (index 0) pushes 0xA0..0xA3 on consecutive cycles with `i_mem_ready`=1. Required: `o_en_mem` high for 4 cycles starting one cycle after the first push; `o_port_num`=1; data in order.
- **Round-robin fairness.** All 3 ports hold 2 words each after reset. Required: tag order 1,2,3,1,2,3 with no bubbles.
- **TDM mode (`pMODE`=0).** Only port 3 has data. Required: a word every third cycle with tag 3; `o_en_mem`=0 in the slots for ports 1 and 2.
- **Backpressure.** `i_mem_ready`=0 for 5 cycles while a word is presented. Required: outputs stable for all 5 cycles, no pops. Pushing 5 words into a depth-4 FIFO leaves `o_ready`=0, drops the fifth word, and sets `o_overflow`=1.
- **Frame lock.** Port 1 sends SOF, mid, (2-cycle gap), EOF while port 2 holds data. Required: port-1 words contiguous on the output, 2 bubble cycles, then port-2 words only after EOF.
- **Reset mid-frame.** Assert `i_reset` for 1 cycle during the frame-lock test. Required: every output equals its reset value the next cycle, all FIFOs are empty, and the next grant goes to port 1.

Source files
------------

// File: rtl/mem_wr_arbiter.sv
// mem_wr_arbiter: per-port skid FIFOs feeding one registered memory-write channel, TDM or round-robin with optional frame lock
module mem_wr_arbiter #(
    parameter int pPORTS      = 3,
    parameter int pDATA_W     = 32,
    parameter int pFIFO_DEPTH = 4,
    parameter int pMODE       = 1,
    parameter int pFRAME_LOCK = 0,
    parameter int pTAG_W      = $clog2(pPORTS + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [pPORTS-1:0]           i_valid,
    input  logic [pPORTS*pDATA_W-1:0]   i_data,
    input  logic [2*pPORTS-1:0]         i_info,
    input  logic [2*pPORTS-1:0]         i_extra_byte,
    output logic [pPORTS-1:0]           o_ready,
    output logic [pPORTS-1:0]           o_overflow,
    input  logic                        i_mem_ready,
    output logic                        o_en_mem,
    output logic [pDATA_W-1:0]          o_data,
    output logic [pTAG_W-1:0]           o_port_num,
    output logic [1:0]                  o_info_port,
    output logic [1:0]                  o_extra_byte
);
    localparam int AW = $clog2(pFIFO_DEPTH);
    localparam int EW = pDATA_W + 4;

    logic [EW-1:0]      mem_q [pPORTS][pFIFO_DEPTH];
    logic [EW-1:0]      mem_d [pPORTS][pFIFO_DEPTH];
    logic [AW-1:0]      wp_q [pPORTS];
    logic [AW-1:0]      wp_d [pPORTS];
    logic [AW-1:0]      rp_q [pPORTS];
    logic [AW-1:0]      rp_d [pPORTS];
    logic [AW:0]        cnt_q [pPORTS];
    logic [AW:0]        cnt_d [pPORTS];
    logic [pPORTS-1:0]  ovf_q, ovf_d;
    logic               en_q, en_d;
    logic [pDATA_W-1:0] data_q, data_d;
    logic [pTAG_W-1:0]  tag_q, tag_d;
    logic [1:0]         info_q, info_d;
    logic [1:0]         xb_q, xb_d;
    logic [pTAG_W-1:0]  slot_q, slot_d;
    logic [pTAG_W-1:0]  last_q, last_d;
    logic [pTAG_W-1:0]  lock_port_q, lock_port_d;
    logic               lock_q, lock_d;
    logic [pPORTS-1:0]  full, empty, push, pop;
    logic               free, gnt_ok;
    logic [pTAG_W-1:0]  gnt;
    logic [EW-1:0]      head;
    int                 idx;

    always_comb begin
        for (int p = 0; p < pPORTS; p++) begin
            full[p]  = cnt_q[p][AW];
            empty[p] = cnt_q[p] == '0;
            push[p]  = i_valid[p] && !full[p];
        end
    end

    // Reverse scan so the last hit is the nearest port after last_q.
    always_comb begin
        gnt    = '0;
        gnt_ok = 1'b0;
        idx    = 0;
        if (pMODE == 0) begin
            gnt    = slot_q;
            gnt_ok = !empty[slot_q];
        end else if (pFRAME_LOCK != 0 && lock_q) begin
            gnt    = lock_port_q;
            gnt_ok = !empty[lock_port_q];
        end else begin
            for (int i = pPORTS; i >= 1; i--) begin
                idx = (int'(last_q) + i) % pPORTS;
                if (!empty[idx]) begin
                    gnt    = pTAG_W'(idx);
                    gnt_ok = 1'b1;
                end
            end
        end
    end

    assign head = mem_q[gnt][rp_q[gnt]];
    assign free = !en_q || i_mem_ready;

    always_comb begin
        mem_d       = mem_q;
        wp_d        = wp_q;
        rp_d        = rp_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q | (i_valid & full);
        en_d        = en_q;
        data_d      = data_q;
        tag_d       = tag_q;
        info_d      = info_q;
        xb_d        = xb_q;
        slot_d      = slot_q;
        last_d      = last_q;
        lock_d      = lock_q;
        lock_port_d = lock_port_q;
        pop         = '0;
        if (free) begin
            en_d = gnt_ok;
            if (pMODE == 0)
                slot_d = (slot_q == pTAG_W'(pPORTS - 1)) ? '0 : slot_q + 1'b1;
            if (gnt_ok) begin
                pop[gnt]                        = 1'b1;
                {data_d, info_d, xb_d}          = head;
                tag_d                           = gnt + 1'b1;
                if (pMODE != 0)
                    last_d = gnt;
                if (pMODE != 0 && pFRAME_LOCK != 0) begin
                    lock_d      = (head[3:2] == 2'b01) ? 1'b1 : head[3] ? 1'b0 : lock_q;
                    lock_port_d = (head[3:2] == 2'b01) ? gnt : lock_port_q;
                end
            end
        end
        for (int p = 0; p < pPORTS; p++) begin
            if (push[p]) begin
                mem_d[p][wp_q[p]] = {i_data[p*pDATA_W +: pDATA_W], i_info[2*p +: 2], i_extra_byte[2*p +: 2]};
                wp_d[p]           = wp_q[p] + 1'b1;
            end
            if (pop[p])
                rp_d[p] = rp_q[p] + 1'b1;
            cnt_d[p] = cnt_q[p] + (AW+1)'(push[p]) - (AW+1)'(pop[p]);
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
        if (i_reset) begin
            wp_q        <= '{default: '0};
            rp_q        <= '{default: '0};
            cnt_q       <= '{default: '0};
            ovf_q       <= '0;
            en_q        <= 1'b0;
            data_q      <= '0;
            tag_q       <= '0;
            info_q      <= '0;
            xb_q        <= '0;
            slot_q      <= '0;
            last_q      <= pTAG_W'(pPORTS - 1);
            lock_q      <= 1'b0;
            lock_port_q <= '0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            en_q        <= en_d;
            data_q      <= data_d;
            tag_q       <= tag_d;
            info_q      <= info_d;
            xb_q        <= xb_d;
            slot_q      <= slot_d;
            last_q      <= last_d;
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
        end
    end

    assign o_ready      = ~full;
    assign o_overflow   = ovf_q;
    assign o_en_mem     = en_q;
    assign o_data       = data_q;
    assign o_port_num   = tag_q;
    assign o_info_port  = info_q;
    assign o_extra_byte = xb_q;
endmodule

// File: tb/tb_mem_wr_arbiter.sv
// tb_mem_wr_arbiter: directed checks of round-robin (u0), TDM (u1) and frame-lock (u2) arbiter instances
module tb_mem_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  valid;
    logic [95:0] data;
    logic [5:0]  info;
    logic [5:0]  xb;
    logic        mem_rdy;
    logic        en   [3];
    logic [31:0] od   [3];
    logic [1:0]  tag  [3];
    logic [1:0]  oi   [3];
    logic [1:0]  ox   [3];
    logic [2:0]  rdy  [3];
    logic [2:0]  ovf  [3];
    int          n_run = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_wr_arbiter #(
            .pPORTS(3), .pDATA_W(32), .pFIFO_DEPTH(4),
            .pMODE(g == 1 ? 0 : 1), .pFRAME_LOCK(g == 2 ? 1 : 0)
        ) u_dut (
            .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_data(data),
            .i_info(info), .i_extra_byte(xb), .o_ready(rdy[g]), .o_overflow(ovf[g]),
            .i_mem_ready(mem_rdy), .o_en_mem(en[g]), .o_data(od[g]),
            .o_port_num(tag[g]), .o_info_port(oi[g]), .o_extra_byte(ox[g])
        );
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", t, got, exp);
        end
    endtask

    task automatic put(input int p, input logic [31:0] d, input logic [1:0] inf, input logic [1:0] x);
        valid[p]       = 1'b1;
        data[p*32 +: 32] = d;
        info[2*p +: 2] = inf;
        xb[2*p +: 2]   = x;
    endtask

    task automatic idle;
        valid = '0;
    endtask

    task automatic do_reset;
        idle();
        mem_rdy = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic out(input string t, input int u, input logic e, input logic [1:0] tg, input logic [31:0] d);
        chk({t, "_en"}, 64'(en[u]), 64'(e));
        if (e) begin
            chk({t, "_tag"}, 64'(tag[u]), 64'(tg));
            chk({t, "_data"}, 64'(od[u]), 64'(d));
        end
    endtask

    task automatic reset_state(input string t, input int u);
        chk({t, "_en"}, 64'(en[u]), 64'd0);
        chk({t, "_data"}, 64'(od[u]), 64'd0);
        chk({t, "_tag"}, 64'(tag[u]), 64'd0);
        chk({t, "_info"}, 64'(oi[u]), 64'd0);
        chk({t, "_xb"}, 64'(ox[u]), 64'd0);
        chk({t, "_ready"}, 64'(rdy[u]), 64'h7);
        chk({t, "_ovf"}, 64'(ovf[u]), 64'd0);
    endtask

    initial begin
        rst = 1'b1; valid = '0; data = '0; info = '0; xb = '0; mem_rdy = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        reset_state("rst_rr", 0);
        reset_state("rst_fl", 2);

        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) put(0, 32'(32'hA0 + i), 2'b11, 2'b00); else idle();
            tick();
            out("single", 0, i >= 1 && i <= 4, 2'd1, 32'(32'hA0 + i - 1));
        end

        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c < 2) for (int p = 0; p < 3; p++) put(p, 32'(16 * (p + 1) + c), 2'b11, 2'b00);
            else idle();
            tick();
            out("rr", 0, c >= 1 && c <= 6, 2'((c - 1) % 3 + 1), 32'(16 * ((c - 1) % 3 + 1) + (c - 1) / 3));
        end

        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (c < 3) put(2, 32'(32'h30 + c), 2'b11, 2'b00); else idle();
            tick();
            out("tdm", 1, c == 2 || c == 5 || c == 8, 2'd3, 32'(32'h30 + (c - 2) / 3));
        end

        do_reset();
        put(0, 32'hB0, 2'b11, 2'b00);
        tick();
        idle();
        tick();
        out("bp_first", 0, 1'b1, 2'd1, 32'hB0);
        mem_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            put(0, 32'(32'hC0 + i), 2'b11, 2'b00);
            tick();
            out("bp_hold", 0, 1'b1, 2'd1, 32'hB0);
            if (i == 3) chk("bp_full_ready", 64'(rdy[0][0]), 64'd0);
        end
        chk("bp_ovf", 64'(ovf[0][0]), 64'd1);
        chk("bp_ready_after_drop", 64'(rdy[0][0]), 64'd0);
        idle();
        mem_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            out("bp_drain", 0, i < 4, 2'd1, 32'(32'hC0 + i));
        end
        chk("bp_ovf_sticky", 64'(ovf[0]), 64'h1);

        do_reset();
        put(0, 32'hF0, 2'b01, 2'b00); put(1, 32'hD0, 2'b11, 2'b01);
        tick();
        out("fl_c0", 2, 1'b0, 2'd0, 32'h0);
        put(0, 32'hF1, 2'b00, 2'b00); put(1, 32'hD1, 2'b11, 2'b10);
        tick();
        out("fl_sof", 2, 1'b1, 2'd1, 32'hF0);
        chk("fl_sof_info", 64'(oi[2]), 64'h1);
        idle();
        tick();
        out("fl_mid", 2, 1'b1, 2'd1, 32'hF1);
        tick();
        out("fl_bubble1", 2, 1'b0, 2'd0, 32'h0);
        put(0, 32'hF2, 2'b10, 2'b11);
        tick();
        out("fl_bubble2", 2, 1'b0, 2'd0, 32'h0);
        idle();
        tick();
        out("fl_eof", 2, 1'b1, 2'd1, 32'hF2);
        chk("fl_eof_info", 64'(oi[2]), 64'h2);
        chk("fl_eof_xb", 64'(ox[2]), 64'h3);
        tick();
        out("fl_p2a", 2, 1'b1, 2'd2, 32'hD0);
        chk("fl_p2a_xb", 64'(ox[2]), 64'h1);
        tick();
        out("fl_p2b", 2, 1'b1, 2'd2, 32'hD1);
        tick();
        out("fl_end", 2, 1'b0, 2'd0, 32'h0);

        do_reset();
        put(0, 32'hF0, 2'b01, 2'b01); put(1, 32'hD0, 2'b11, 2'b00);
        tick();
        put(0, 32'hF1, 2'b00, 2'b00); valid[1] = 1'b0;
        tick();
        out("mr_sof", 2, 1'b1, 2'd1, 32'hF0);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reset_state("mr_rst", 2);
        tick();
        out("mr_empty", 2, 1'b0, 2'd0, 32'h0);
        put(0, 32'hE0, 2'b11, 2'b00); put(1, 32'hE1, 2'b11, 2'b00);
        tick();
        idle();
        out("mr_c0", 2, 1'b0, 2'd0, 32'h0);
        tick();
        out("mr_first", 2, 1'b1, 2'd1, 32'hE0);
        tick();
        out("mr_second", 2, 1'b1, 2'd2, 32'hE1);
        tick();
        out("mr_end", 2, 1'b0, 2'd0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
